// File: rtl/fft_bfly_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bfly_ctrl_if
//  Description : Operand-in / result-out handshake bundle for fft_bfly_ctrl.
//                Signal suffixes give the direction as seen by the controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface fft_bfly_ctrl_if;
   // operand side
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] a_re_i;
   logic [15:0] a_im_i;
   logic [15:0] b_re_i;
   logic [15:0] b_im_i;
   logic [15:0] w_re_i;
   logic [15:0] w_im_i;
   logic        abort_i;
   // result side
   logic        out_valid_o;
   logic        out_ready_i;
   logic [15:0] x_re_o;
   logic [15:0] x_im_o;
   logic [15:0] y_re_o;
   logic [15:0] y_im_o;
   logic        busy_o;

   // Producer/consumer of butterflies (stage address/memory logic)
   modport master (
      output in_valid_i, a_re_i, a_im_i, b_re_i, b_im_i, w_re_i, w_im_i,
             abort_i, out_ready_i,
      input  in_ready_o, out_valid_o, x_re_o, x_im_o, y_re_o, y_im_o, busy_o
   );

   // The butterfly controller itself
   modport slave (
      input  in_valid_i, a_re_i, a_im_i, b_re_i, b_im_i, w_re_i, w_im_i,
             abort_i, out_ready_i,
      output in_ready_o, out_valid_o, x_re_o, x_im_o, y_re_o, y_im_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/fft_bfly_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bfly_ctrl
//  Description : Sequences one shared combinational fft_alu through a complex
//                radix-2 DIT butterfly X = A + W*B, Y = A - W*B in 10 steps.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef ALUMODE_IDLE
`define ALUMODE_IDLE    5'd0
`define ALUMODE_ADD_B   5'd1
`define ALUMODE_SUB_B   5'd2
`define ALUMODE_MULT_B  5'd3
`define ALUMODE_A_ADD_C 5'd4
`endif

module fft_bfly_ctrl #(
   parameter int unsigned SCALE     = 1,  // 1: X/Y = res[16:1]; 0: X/Y = sat16(res)
   parameter int unsigned ROUND_MUL = 0   // 1: round products; 0: truncate
) (
   input  wire logic        clk,
   input  wire logic        rst,          // asynchronous, active-low
   fft_bfly_ctrl_if.slave   bus,
   output logic [15:0]      alu_op_a_o,
   output logic [15:0]      alu_op_b_o,
   output logic [15:0]      alu_op_c_o,
   output logic [4:0]       alu_mode_o,
   input  wire logic [31:0] alu_res_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_STEP = 4'd9;

   state_t      state_q, state_d;
   logic [3:0]  step_q, step_d;

   logic [15:0] a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
   logic [15:0] t0_q, t1_q, t2_q, t3_q, tr_q, ti_q;
   logic [15:0] xr_q, yr_q, xi_q, yi_q;          // finished results, not yet presented
   logic [15:0] x_re_q, x_im_q, y_re_q, y_im_q;  // presented results
   logic        out_valid_q;

   logic [4:0]  mode_c;
   logic [15:0] op_a_c, op_b_c, op_c_c;
   logic        accept;

   logic signed [32:0] res_ext;
   logic signed [32:0] prod_shift;
   logic [15:0]        prod_sat;
   logic [15:0]        res_sat;
   logic [15:0]        res_fin;

   function automatic logic [15:0] sat16(input logic signed [32:0] v);
      logic [15:0] r;
      if (v > 33'sd32767)       r = 16'h7FFF;
      else if (v < -33'sd32768) r = 16'h8000;
      else                      r = v[15:0];
      return r;
   endfunction

   // Abort in IDLE blocks a simultaneous accept
   assign accept = (state_q == ST_IDLE) && bus.in_valid_i && !bus.abort_i;

   // One extra bit keeps the rounding add free of overflow
   assign res_ext    = $signed({alu_res_i[31], alu_res_i});
   assign prod_shift = (res_ext + ((ROUND_MUL != 0) ? 33'sd16384 : 33'sd0)) >>> 15;
   assign prod_sat   = sat16(prod_shift);
   assign res_sat    = sat16(res_ext);
   assign res_fin    = (SCALE != 0) ? alu_res_i[16:1] : res_sat;

   // State and step register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         step_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   // Next state and per-step ALU operand/mode decode
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      mode_c  = `ALUMODE_IDLE;
      op_a_c  = 16'h0000;
      op_b_c  = 16'h0000;
      op_c_c  = 16'h0000;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_RUN;
               step_d  = 4'd0;
            end
         end
         ST_RUN: begin
            case (step_q)
               4'd0: begin mode_c = `ALUMODE_MULT_B;  op_a_c = b_re_q; op_b_c = w_re_q; end
               4'd1: begin mode_c = `ALUMODE_MULT_B;  op_a_c = b_im_q; op_b_c = w_im_q; end
               4'd2: begin mode_c = `ALUMODE_MULT_B;  op_a_c = b_re_q; op_b_c = w_im_q; end
               4'd3: begin mode_c = `ALUMODE_MULT_B;  op_a_c = b_im_q; op_b_c = w_re_q; end
               4'd4: begin mode_c = `ALUMODE_SUB_B;   op_a_c = t0_q;   op_b_c = t1_q;   end
               4'd5: begin mode_c = `ALUMODE_ADD_B;   op_a_c = t2_q;   op_b_c = t3_q;   end
               4'd6: begin mode_c = `ALUMODE_ADD_B;   op_a_c = a_re_q; op_b_c = tr_q;   end
               4'd7: begin mode_c = `ALUMODE_SUB_B;   op_a_c = a_re_q; op_b_c = tr_q;   end
               4'd8: begin mode_c = `ALUMODE_A_ADD_C; op_a_c = a_im_q; op_c_c = ti_q;   end
               4'd9: begin mode_c = `ALUMODE_SUB_B;   op_a_c = a_im_q; op_b_c = ti_q;   end
               default: mode_c = `ALUMODE_IDLE;
            endcase
            if (bus.abort_i) begin
               state_d = ST_IDLE;
               step_d  = 4'd0;
            end else if (step_q == LAST_STEP) begin
               state_d = ST_DONE;
               step_d  = 4'd0;
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (bus.abort_i || (out_valid_q && bus.out_ready_i)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand capture and per-step result capture from the ALU
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_re_q <= 16'h0; a_im_q <= 16'h0;
         b_re_q <= 16'h0; b_im_q <= 16'h0;
         w_re_q <= 16'h0; w_im_q <= 16'h0;
         t0_q   <= 16'h0; t1_q   <= 16'h0;
         t2_q   <= 16'h0; t3_q   <= 16'h0;
         tr_q   <= 16'h0; ti_q   <= 16'h0;
         xr_q   <= 16'h0; yr_q   <= 16'h0;
         xi_q   <= 16'h0; yi_q   <= 16'h0;
      end else begin
         if (accept) begin
            a_re_q <= bus.a_re_i; a_im_q <= bus.a_im_i;
            b_re_q <= bus.b_re_i; b_im_q <= bus.b_im_i;
            w_re_q <= bus.w_re_i; w_im_q <= bus.w_im_i;
         end
         if ((state_q == ST_RUN) && !bus.abort_i) begin
            case (step_q)
               4'd0: t0_q <= prod_sat;
               4'd1: t1_q <= prod_sat;
               4'd2: t2_q <= prod_sat;
               4'd3: t3_q <= prod_sat;
               4'd4: tr_q <= res_sat;
               4'd5: ti_q <= res_sat;
               4'd6: xr_q <= res_fin;
               4'd7: yr_q <= res_fin;
               4'd8: xi_q <= res_fin;
               4'd9: yi_q <= res_fin;
               default: ;
            endcase
         end
      end
   end

   // Present results one cycle into DONE; hold them until accepted or aborted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         x_re_q      <= 16'h0;
         x_im_q      <= 16'h0;
         y_re_q      <= 16'h0;
         y_im_q      <= 16'h0;
      end else if ((state_q == ST_DONE) && !bus.abort_i) begin
         if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            x_re_q      <= xr_q;
            x_im_q      <= xi_q;
            y_re_q      <= yr_q;
            y_im_q      <= yi_q;
         end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
         end
      end else begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready_o  = (state_q == ST_IDLE) && rst;
   assign bus.out_valid_o = out_valid_q;
   assign bus.busy_o      = (state_q != ST_IDLE);
   assign bus.x_re_o      = x_re_q;
   assign bus.x_im_o      = x_im_q;
   assign bus.y_re_o      = y_re_q;
   assign bus.y_im_o      = y_im_q;

   assign alu_mode_o = mode_c;
   assign alu_op_a_o = op_a_c;
   assign alu_op_b_o = op_b_c;
   assign alu_op_c_o = op_c_c;

endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_bfly_ctrl
//  Description : Directed bench for fft_bfly_ctrl; two instances
//                (SCALE=0/ROUND_MUL=0 and SCALE=1/ROUND_MUL=1) share stimulus,
//                each driving its own fft_alu stand-in.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef ALUMODE_IDLE
`define ALUMODE_IDLE    5'd0
`define ALUMODE_ADD_B   5'd1
`define ALUMODE_SUB_B   5'd2
`define ALUMODE_MULT_B  5'd3
`define ALUMODE_A_ADD_C 5'd4
`endif

module tb_fft_bfly_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fft_bfly_ctrl_if if0 ();
   fft_bfly_ctrl_if if1 ();

   logic [15:0] opa0, opb0, opc0, opa1, opb1, opc1;
   logic [4:0]  mode0, mode1;
   logic [31:0] res0, res1;

   localparam logic [4:0] MODE_SEQ [10] = '{
      `ALUMODE_MULT_B, `ALUMODE_MULT_B, `ALUMODE_MULT_B, `ALUMODE_MULT_B,
      `ALUMODE_SUB_B, `ALUMODE_ADD_B, `ALUMODE_ADD_B, `ALUMODE_SUB_B,
      `ALUMODE_A_ADD_C, `ALUMODE_SUB_B};

   fft_bfly_ctrl #(.SCALE(0), .ROUND_MUL(0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave),
      .alu_op_a_o(opa0), .alu_op_b_o(opb0), .alu_op_c_o(opc0),
      .alu_mode_o(mode0), .alu_res_i(res0));

   fft_bfly_ctrl #(.SCALE(1), .ROUND_MUL(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave),
      .alu_op_a_o(opa1), .alu_op_b_o(opb1), .alu_op_c_o(opc1),
      .alu_mode_o(mode1), .alu_res_i(res1));

   // fft_alu stand-in: signed 16-bit operands, 32-bit result
   function automatic logic [31:0] alu_model(input logic [4:0] m, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] c);
      logic signed [31:0] sa, sb, sc;
      logic [31:0] r;
      sa = 32'($signed(a));
      sb = 32'($signed(b));
      sc = 32'($signed(c));
      case (m)
         `ALUMODE_MULT_B:  r = sa * sb;
         `ALUMODE_ADD_B:   r = sa + sb;
         `ALUMODE_SUB_B:   r = sa - sb;
         `ALUMODE_A_ADD_C: r = sa + sc;
         default:          r = 32'h0;
      endcase
      return r;
   endfunction

   assign res0 = alu_model(mode0, opa0, opb0, opc0);
   assign res1 = alu_model(mode1, opa1, opb1, opc1);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] br, input logic [15:0] bi,
                         input logic [15:0] wr, input logic [15:0] wi);
      if0.in_valid_i = v; if1.in_valid_i = v;
      if0.a_re_i = ar; if1.a_re_i = ar;
      if0.a_im_i = ai; if1.a_im_i = ai;
      if0.b_re_i = br; if1.b_re_i = br;
      if0.b_im_i = bi; if1.b_im_i = bi;
      if0.w_re_i = wr; if1.w_re_i = wr;
      if0.w_im_i = wi; if1.w_im_i = wi;
   endtask

   task automatic set_ctl(input logic abort, input logic ordy);
      if0.abort_i = abort;   if1.abort_i = abort;
      if0.out_ready_i = ordy; if1.out_ready_i = ordy;
   endtask

   function automatic logic [63:0] xy0();
      return {if0.x_re_o, if0.x_im_o, if0.y_re_o, if0.y_im_o};
   endfunction

   function automatic logic [63:0] xy1();
      return {if1.x_re_o, if1.x_im_o, if1.y_re_o, if1.y_im_o};
   endfunction

   // One butterfly: accept, step-by-step mode checks, latency, results,
   // optional back-pressure, then output handshake. e0/e1 = {Xr,Xi,Yr,Yi}.
   task automatic run_bfly(input string tag,
                           input logic [15:0] ar, input logic [15:0] ai,
                           input logic [15:0] br, input logic [15:0] bi,
                           input logic [15:0] wr, input logic [15:0] wi,
                           input logic [63:0] e0, input logic [63:0] e1,
                           input logic [15:0] ti0, input int hold);
      chk({tag, ":in_ready"}, 64'({if0.in_ready_o, if1.in_ready_o}), 64'd3);
      set_in(1'b1, ar, ai, br, bi, wr, wi);
      @(posedge clk); #1;
      set_in(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      for (int s = 0; s < 10; s++) begin
         chk($sformatf("%s:mode%0d", tag, s), 64'(mode0), 64'(MODE_SEQ[s]));
         if (s == 8) begin
            chk({tag, ":op_c8"}, 64'(opc0), 64'(ti0));
            chk({tag, ":op_b8"}, 64'(opb0), 64'd0);
         end
         if (s == 9) chk({tag, ":op_c9"}, 64'(opc0), 64'd0);
         @(posedge clk); #1;
      end
      chk({tag, ":done_nvalid"}, 64'({if0.out_valid_o, if0.busy_o, mode0}),
          64'({1'b0, 1'b1, `ALUMODE_IDLE}));
      @(posedge clk); #1;
      chk({tag, ":valid"}, 64'({if0.out_valid_o, if1.out_valid_o}), 64'd3);
      chk({tag, ":xy0"}, xy0(), e0);
      chk({tag, ":xy1"}, xy1(), e1);
      for (int h = 0; h < hold; h++) begin
         set_in(1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
         @(posedge clk); #1;
         chk($sformatf("%s:hold%0d_vr", tag, h),
             64'({if0.out_valid_o, if0.in_ready_o, if1.out_valid_o}), 64'b101);
         chk($sformatf("%s:hold%0d_xy", tag, h), xy0(), e0);
      end
      set_in(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      set_ctl(1'b0, 1'b1);
      @(posedge clk); #1;
      set_ctl(1'b0, 1'b0);
      chk({tag, ":after_vbr"}, 64'({if0.out_valid_o, if0.busy_o, if0.in_ready_o}), 64'b001);
      chk({tag, ":retain"}, xy0(), e0);
   endtask

   initial begin
      logic seen_valid;
      rst = 1'b0;
      set_in(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      set_ctl(1'b0, 1'b0);
      #12;
      chk("rst:outs", 64'({if0.in_ready_o, if0.out_valid_o, if0.busy_o, mode0}),
          64'({3'b000, `ALUMODE_IDLE}));
      chk("rst:ops", 64'({opa0, opb0, opc0}), 64'd0);
      chk("rst:xy", xy0(), 64'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("rst:ready", 64'(if0.in_ready_o), 64'd1);

      run_bfly("v2", 16'h1000, 16'h0000, 16'h0800, 16'h0000, 16'h7FFF, 16'h0000,
               64'h17FF_0000_0801_0000, 64'h0C00_0000_0400_0000, 16'h0000, 0);
      run_bfly("v3", 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000,
               64'h7FFF_0000_0001_0000, 64'h7FFE_0000_0000_0000, 16'h0000, 0);
      run_bfly("v4", 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000,
               64'h7FFF_0000_8001_0000, 64'h3FFF_0000_C000_0000, 16'h0000, 0);
      run_bfly("cpx", 16'h0100, 16'h0200, 16'h0400, 16'hFE00, 16'h4000, 16'hC000,
               64'h0200_FF00_0000_0500, 64'h0100_FF80_0000_0280, 16'hFD00, 5);
      run_bfly("rnd", 16'h0002, 16'h0000, 16'h4000, 16'h4000, 16'h0003, 16'h0000,
               64'h0003_0001_0001_FFFF, 64'h0002_0001_0000_FFFF, 16'h0001, 0);

      // Abort during step 4
      set_in(1'b1, 16'h1000, 16'h0000, 16'h0800, 16'h0000, 16'h7FFF, 16'h0000);
      @(posedge clk); #1;
      set_in(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (4) @(posedge clk);
      #1;
      chk("abort:step4_mode", 64'(mode0), 64'(`ALUMODE_SUB_B));
      set_ctl(1'b1, 1'b0);
      @(posedge clk); #1;
      set_ctl(1'b0, 1'b0);
      chk("abort:idle", 64'({if0.busy_o, if1.busy_o, if0.in_ready_o, mode0}),
          64'({3'b001, `ALUMODE_IDLE}));
      seen_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         seen_valid = seen_valid | if0.out_valid_o | if1.out_valid_o;
      end
      chk("abort:no_valid", 64'(seen_valid), 64'd0);
      chk("abort:xy0", xy0(), 64'h0003_0001_0001_FFFF);
      chk("abort:xy1", xy1(), 64'h0002_0001_0000_FFFF);
      run_bfly("v3b", 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000,
               64'h7FFF_0000_0001_0000, 64'h7FFE_0000_0000_0000, 16'h0000, 0);

      // Abort while idle also blocks a simultaneous accept
      set_in(1'b1, 16'h1000, 16'h0000, 16'h0800, 16'h0000, 16'h7FFF, 16'h0000);
      set_ctl(1'b1, 1'b0);
      @(posedge clk); #1;
      set_in(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      set_ctl(1'b0, 1'b0);
      chk("idle_abort:busy", 64'({if0.busy_o, if1.busy_o}), 64'd0);

      // Reset in the middle of a run
      set_in(1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
      @(posedge clk); #1;
      set_in(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (3) @(posedge clk);
      #3;
      chk("midrst:pre_busy", 64'(if0.busy_o), 64'd1);
      rst = 1'b0;
      #1;
      chk("midrst:outs", 64'({if0.in_ready_o, if0.out_valid_o, if0.busy_o, mode0, mode1}),
          64'({3'b000, `ALUMODE_IDLE, `ALUMODE_IDLE}));
      chk("midrst:ops", 64'({opa0, opb0, opc0}), 64'd0);
      chk("midrst:xy0", xy0(), 64'd0);
      chk("midrst:xy1", xy1(), 64'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst:ready", 64'({if0.in_ready_o, if1.in_ready_o}), 64'd3);
      run_bfly("v2b", 16'h1000, 16'h0000, 16'h0800, 16'h0000, 16'h7FFF, 16'h0000,
               64'h17FF_0000_0801_0000, 64'h0C00_0000_0400_0000, 16'h0000, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
